id_exe_reg: RTL and testbench

//  Pipeline register between decode (which reads the 16x32 register file) and execute.

---
 rtl/arm_pkg.sv | 49 ++++
 rtl/pipe_field.sv | 29 ++
 rtl/id_exe_reg.sv | 99 +++++++++
 tb/tb_id_exe_reg.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/arm_pkg.sv
// Shared widths, ALU command encodings and pipeline bundle types.
package arm_pkg;

  localparam int WORD_W     = 32;
  localparam int REG_ADDR_W = 4;
  localparam int CMD_W      = 4;

  typedef enum logic [CMD_W-1:0] {
    CMD_NOP = 4'b0000,
    CMD_MOV = 4'b0001,
    CMD_ADD = 4'b0010,
    CMD_ADC = 4'b0011,
    CMD_SUB = 4'b0100,
    CMD_SBC = 4'b0101,
    CMD_AND = 4'b0110,
    CMD_ORR = 4'b0111,
    CMD_EOR = 4'b1000,
    CMD_MVN = 4'b1001
  } exe_cmd_e;

  // Everything that may have side effects downstream; cleared for a bubble.
  typedef struct packed {
    logic valid;
    logic wb_en;
    logic mem_r_en;
    logic mem_w_en;
    logic b;
    logic s;
  } ctrl_t;

  // Operands and decoded fields; carried verbatim, no extension here.
  typedef struct packed {
    logic [WORD_W-1:0]     pc;
    logic [WORD_W-1:0]     val_rn;
    logic [WORD_W-1:0]     val_rm;
    logic [REG_ADDR_W-1:0] src1;
    logic [REG_ADDR_W-1:0] src2;
    logic [REG_ADDR_W-1:0] dest;
    logic [CMD_W-1:0]      exe_cmd;
    logic                  imm;
    logic [11:0]           shift_op;
    logic [23:0]           simm24;
    logic                  carry;
  } data_t;

  localparam ctrl_t CTRL_NOP = '0;
  localparam data_t DATA_NOP = '0;

endpackage

// File: rtl/pipe_field.sv
// Generic pipeline flop: sync reset, hold when en=0, load zero when clr=1.
module pipe_field #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         clr,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] q_q;
  logic [W-1:0] q_d;

  // Clear beats load; hold is handled by the enable.
  always_comb begin
    q_d = clr ? '0 : d_i;
  end

  // Reset beats hold so a stalled pipe can still be cleared.
  always_ff @(posedge clk) begin
    if (rst)     q_q <= '0;
    else if (en) q_q <= q_d;
  end

  assign q_o = q_q;

endmodule

// File: rtl/id_exe_reg.sv
// ID/EXE pipeline register with freeze (stall) and flush (bubble insertion).
module id_exe_reg
  import arm_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  freeze,
  input  logic                  flush,
  input  logic                  id_valid,
  input  logic [WORD_W-1:0]     id_pc,
  input  logic [WORD_W-1:0]     id_val_rn,
  input  logic [WORD_W-1:0]     id_val_rm,
  input  logic [REG_ADDR_W-1:0] id_src1,
  input  logic [REG_ADDR_W-1:0] id_src2,
  input  logic [REG_ADDR_W-1:0] id_dest,
  input  logic [CMD_W-1:0]      id_exe_cmd,
  input  logic                  id_mem_r_en,
  input  logic                  id_mem_w_en,
  input  logic                  id_wb_en,
  input  logic                  id_b,
  input  logic                  id_s,
  input  logic                  id_imm,
  input  logic [11:0]           id_shift_op,
  input  logic [23:0]           id_simm24,
  input  logic                  id_carry,
  output logic                  exe_valid,
  output logic [WORD_W-1:0]     exe_pc,
  output logic [WORD_W-1:0]     exe_val_rn,
  output logic [WORD_W-1:0]     exe_val_rm,
  output logic [REG_ADDR_W-1:0] exe_src1,
  output logic [REG_ADDR_W-1:0] exe_src2,
  output logic [REG_ADDR_W-1:0] exe_dest,
  output logic [CMD_W-1:0]      exe_exe_cmd,
  output logic                  exe_mem_r_en,
  output logic                  exe_mem_w_en,
  output logic                  exe_wb_en,
  output logic                  exe_b,
  output logic                  exe_s,
  output logic                  exe_imm,
  output logic [11:0]           exe_shift_op,
  output logic [23:0]           exe_simm24,
  output logic                  exe_carry
);

  ctrl_t ctrl_d, ctrl_q;
  data_t data_d, data_q;
  logic  load_en;
  logic  ctrl_clr;

  // Freeze gates every flop; an invalid decode slot kills the enables
  // but its data is still captured.
  always_comb begin
    load_en  = ~freeze;
    ctrl_clr = flush | ~id_valid;
    ctrl_d   = '{valid: id_valid, wb_en: id_wb_en, mem_r_en: id_mem_r_en,
                 mem_w_en: id_mem_w_en, b: id_b, s: id_s};
    data_d   = '{pc: id_pc, val_rn: id_val_rn, val_rm: id_val_rm,
                 src1: id_src1, src2: id_src2, dest: id_dest,
                 exe_cmd: id_exe_cmd, imm: id_imm, shift_op: id_shift_op,
                 simm24: id_simm24, carry: id_carry};
  end

  pipe_field #(.W($bits(ctrl_t))) u_ctrl (
    .clk (clk),
    .rst (rst),
    .en  (load_en),
    .clr (ctrl_clr),
    .d_i (ctrl_d),
    .q_o (ctrl_q)
  );

  pipe_field #(.W($bits(data_t))) u_data (
    .clk (clk),
    .rst (rst),
    .en  (load_en),
    .clr (flush),
    .d_i (data_d),
    .q_o (data_q)
  );

  assign exe_valid    = ctrl_q.valid;
  assign exe_wb_en    = ctrl_q.wb_en;
  assign exe_mem_r_en = ctrl_q.mem_r_en;
  assign exe_mem_w_en = ctrl_q.mem_w_en;
  assign exe_b        = ctrl_q.b;
  assign exe_s        = ctrl_q.s;
  assign exe_pc       = data_q.pc;
  assign exe_val_rn   = data_q.val_rn;
  assign exe_val_rm   = data_q.val_rm;
  assign exe_src1     = data_q.src1;
  assign exe_src2     = data_q.src2;
  assign exe_dest     = data_q.dest;
  assign exe_exe_cmd  = data_q.exe_cmd;
  assign exe_imm      = data_q.imm;
  assign exe_shift_op = data_q.shift_op;
  assign exe_simm24   = data_q.simm24;
  assign exe_carry    = data_q.carry;

endmodule

// File: tb/tb_id_exe_reg.sv
// Randomized bench for id_exe_reg against a behavioural next-state model.
module tb_id_exe_reg;

  typedef struct packed {
    logic        valid;
    logic        wb;
    logic        mr;
    logic        mw;
    logic        b;
    logic        s;
    logic        imm;
    logic        carry;
    logic [31:0] pc;
    logic [31:0] rn;
    logic [31:0] rm;
    logic [3:0]  src1;
    logic [3:0]  src2;
    logic [3:0]  dest;
    logic [3:0]  cmd;
    logic [11:0] sh;
    logic [23:0] simm;
  } io_t;

  logic clk = 1'b0;
  logic rst, freeze, flush;
  io_t  id, obs, exp_s;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  id_exe_reg dut (
    .clk          (clk),
    .rst          (rst),
    .freeze       (freeze),
    .flush        (flush),
    .id_valid     (id.valid),
    .id_pc        (id.pc),
    .id_val_rn    (id.rn),
    .id_val_rm    (id.rm),
    .id_src1      (id.src1),
    .id_src2      (id.src2),
    .id_dest      (id.dest),
    .id_exe_cmd   (id.cmd),
    .id_mem_r_en  (id.mr),
    .id_mem_w_en  (id.mw),
    .id_wb_en     (id.wb),
    .id_b         (id.b),
    .id_s         (id.s),
    .id_imm       (id.imm),
    .id_shift_op  (id.sh),
    .id_simm24    (id.simm),
    .id_carry     (id.carry),
    .exe_valid    (obs.valid),
    .exe_pc       (obs.pc),
    .exe_val_rn   (obs.rn),
    .exe_val_rm   (obs.rm),
    .exe_src1     (obs.src1),
    .exe_src2     (obs.src2),
    .exe_dest     (obs.dest),
    .exe_exe_cmd  (obs.cmd),
    .exe_mem_r_en (obs.mr),
    .exe_mem_w_en (obs.mw),
    .exe_wb_en    (obs.wb),
    .exe_b        (obs.b),
    .exe_s        (obs.s),
    .exe_imm      (obs.imm),
    .exe_shift_op (obs.sh),
    .exe_simm24   (obs.simm),
    .exe_carry    (obs.carry)
  );

  // Reference behaviour: reset clears, freeze holds, flush gives an all-zero
  // bubble, otherwise copy with side-effect bits dropped for invalid slots.
  function automatic io_t ref_next(io_t cur, io_t in, logic r, logic fz, logic fl);
    io_t n;
    if (r)  return '0;
    if (fz) return cur;
    if (fl) return '0;
    n = in;
    if (!in.valid) begin
      n.wb = 1'b0; n.mr = 1'b0; n.mw = 1'b0; n.b = 1'b0; n.s = 1'b0;
    end
    return n;
  endfunction

  task automatic rand_id();
    id = io_t'({$urandom, $urandom, $urandom, $urandom, $urandom, $urandom});
  endtask

  // One clock: model follows the inputs present at the edge, then settle to negedge.
  task automatic tick();
    @(posedge clk);
    exp_s = ref_next(exp_s, id, rst, freeze, flush);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1; freeze = 1'b0; flush = 1'b0;
    for (int i = 0; i < 2; i++) begin
      rand_id();
      tick();
      n_tests++;
      if (obs !== io_t'(0)) begin
        n_fail++;
        $display("FAIL reset[%0d]: got %h want 0", i, obs);
      end
    end
    rst = 1'b0;
  endtask

  task automatic test_load();
    rand_id();
    id.valid = 1'b1; id.rn = 32'h0000_0005; id.rm = 32'hFFFF_FFFB;
    id.dest = 4'd3; id.wb = 1'b1; id.cmd = 4'b0010;
    tick();
    n_tests++;
    if (obs.valid !== 1'b1 || obs.rn !== 32'h0000_0005 || obs.rm !== 32'hFFFF_FFFB ||
        obs.dest !== 4'd3 || obs.wb !== 1'b1 || obs.cmd !== 4'b0010) begin
      n_fail++;
      $display("FAIL load_fields: got v=%b rn=%h rm=%h d=%0d wb=%b cmd=%h",
               obs.valid, obs.rn, obs.rm, obs.dest, obs.wb, obs.cmd);
    end
    n_tests++;
    if (obs !== exp_s) begin
      n_fail++;
      $display("FAIL load_all: got %h want %h", obs, exp_s);
    end
  endtask

  task automatic test_freeze();
    io_t held;
    held = obs;
    freeze = 1'b1;
    for (int i = 0; i < 3; i++) begin
      rand_id();
      tick();
      n_tests++;
      if (obs !== held) begin
        n_fail++;
        $display("FAIL freeze_hold[%0d]: got %h want %h", i, obs, held);
      end
    end
    freeze = 1'b0;
    rand_id(); id.valid = 1'b1; id.pc = 32'hCAFE_0004;
    tick();
    n_tests++;
    if (obs !== exp_s || obs.pc !== 32'hCAFE_0004) begin
      n_fail++;
      $display("FAIL freeze_release: got %h want %h", obs, exp_s);
    end
  endtask

  task automatic test_flush();
    rand_id(); id.valid = 1'b1; id.wb = 1'b1; id.mw = 1'b1; id.pc = 32'h0000_1234;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    n_tests++;
    if (obs.valid !== 1'b0 || obs.wb !== 1'b0 || obs.mw !== 1'b0 || obs.pc !== 32'h0) begin
      n_fail++;
      $display("FAIL flush_bubble: got v=%b wb=%b mw=%b pc=%h want 0 0 0 0",
               obs.valid, obs.wb, obs.mw, obs.pc);
    end
    n_tests++;
    if (obs !== io_t'(0)) begin
      n_fail++;
      $display("FAIL flush_all: got %h want 0", obs);
    end
  endtask

  task automatic test_freeze_flush();
    io_t held;
    rand_id(); id.valid = 1'b1; id.wb = 1'b1;
    tick();
    held = obs;
    rand_id();
    freeze = 1'b1; flush = 1'b1;
    tick();
    n_tests++;
    if (obs !== held || obs.valid !== 1'b1) begin
      n_fail++;
      $display("FAIL freeze_over_flush: got %h want %h", obs, held);
    end
    // flush must not be remembered after freeze drops
    freeze = 1'b0; flush = 1'b0; rand_id(); id.valid = 1'b1;
    tick();
    n_tests++;
    if (obs !== exp_s || obs.valid !== 1'b1) begin
      n_fail++;
      $display("FAIL flush_not_latched: got %h want %h", obs, exp_s);
    end
  endtask

  task automatic test_invalid();
    rand_id(); id.valid = 1'b0; id.wb = 1'b1; id.mw = 1'b1; id.dest = 4'd15;
    tick();
    n_tests++;
    if (obs.wb !== 1'b0 || obs.valid !== 1'b0 || obs.mw !== 1'b0 || obs.dest !== 4'd15) begin
      n_fail++;
      $display("FAIL invalid_in: got v=%b wb=%b mw=%b dest=%0d want 0 0 0 15",
               obs.valid, obs.wb, obs.mw, obs.dest);
    end
  endtask

  task automatic test_rst_in_freeze();
    rand_id(); id.valid = 1'b1; id.wb = 1'b1;
    tick();
    freeze = 1'b1; rst = 1'b1; rand_id();
    tick();
    n_tests++;
    if (obs !== io_t'(0)) begin
      n_fail++;
      $display("FAIL rst_in_freeze: got %h want 0", obs);
    end
    rst = 1'b0; freeze = 1'b0; rand_id(); id.valid = 1'b1; id.rn = 32'h1357_9BDF;
    tick();
    n_tests++;
    if (obs !== exp_s || obs.rn !== 32'h1357_9BDF) begin
      n_fail++;
      $display("FAIL post_rst_load: got %h want %h", obs, exp_s);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      rand_id();
      rst    = ($urandom_range(0, 19) == 0);
      freeze = ($urandom_range(0, 3) == 0);
      flush  = ($urandom_range(0, 4) == 0);
      tick();
      n_tests++;
      if (obs !== exp_s) begin
        n_fail++;
        $display("FAIL random[%0d]: got %h want %h", i, obs, exp_s);
      end
      n_tests++;
      if (!obs.valid && (obs.wb | obs.mr | obs.mw | obs.b | obs.s) !== 1'b0) begin
        n_fail++;
        $display("FAIL bubble_invariant[%0d]: got wb=%b mr=%b mw=%b b=%b s=%b want 0",
                 i, obs.wb, obs.mr, obs.mw, obs.b, obs.s);
      end
    end
    rst = 1'b0; freeze = 1'b0; flush = 1'b0;
  endtask

  initial begin
    rst = 1'b1; freeze = 1'b0; flush = 1'b0; id = '0; exp_s = '0;
    @(negedge clk);
    test_reset();
    test_load();
    test_freeze();
    test_flush();
    test_freeze_flush();
    test_invalid();
    test_rst_in_freeze();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
